simproc_ctrl: RTL and testbench

- Parametrised run controller and program memory for simproc; replaces the bench-side memory array and hierarchical register pokes.
- Host command port loads and reads memory, sets the start PC, and launches or aborts a run.
- Processor-side port uses the existing simproc memory handshake: combinational read, synchronous write.
- Controller counts run cycles, enforces a timeout and reports the stop reason. Sits between the host/bench and simproc.

---
 rtl/simproc_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_simproc_ctrl.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simproc_ctrl.sv
// ---------------------------------------------------------------------------
// simproc_ctrl
//
// Run controller and program memory for the simproc processor. A host-side
// command port loads and reads the program memory, sets the start PC, and
// launches or aborts a run. The processor side sees the usual simproc memory
// handshake (combinational read, synchronous write) plus a PC-load strobe
// and a run enable. The controller counts run cycles, enforces a cycle
// budget and reports why the last run stopped.
//
// Optional feature: define SIMPROC_CTRL_BKPT_EN to add a single address
// breakpoint on the processor memory address bus.
//
// Ports:
//   clk, rst                  clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready       host command handshake
//   cmd_op                    00 WRITE, 01 READ, 10 START, 11 ABORT
//   cmd_addr, cmd_wdata       memory address or start PC, write data
//   rsp_valid, rsp_data       READ response, one-cycle pulse
//   cpu_mem_addr/din/we/dout  processor memory port
//   cpu_pc_set_val/wr         PC load value and strobe
//   cpu_run, cpu_done         run enable out, completion in
//   busy, stop_reason         controller not idle, why the last run stopped
//   cycle_count               RUN cycles of the last or current run
//   bkpt_en/addr/hit          breakpoint controls (SIMPROC_CTRL_BKPT_EN only)
// ---------------------------------------------------------------------------
module simproc_ctrl #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 8,
    parameter int CNT_W      = 16,
    // Must lie in 1 .. 2**CNT_W-1 so the counter can reach it.
    parameter int MAX_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    input  logic [ADDR_W-1:0] cpu_mem_addr,
    input  logic [DATA_W-1:0] cpu_mem_din,
    input  logic              cpu_mem_we,
    output logic [DATA_W-1:0] cpu_mem_dout,
    output logic [DATA_W-1:0] cpu_pc_set_val,
    output logic              cpu_pc_set_wr,
    output logic              cpu_run,
    input  logic              cpu_done,
    output logic              busy,
    output logic [1:0]        stop_reason,
`ifdef SIMPROC_CTRL_BKPT_EN
    input  logic              bkpt_en,
    input  logic [ADDR_W-1:0] bkpt_addr,
    output logic              bkpt_hit,
`endif
    output logic [CNT_W-1:0]  cycle_count
);

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_START = 2'b10;
    localparam logic [1:0] OP_ABORT = 2'b11;

    localparam logic [1:0] STOP_NONE    = 2'b00;
    localparam logic [1:0] STOP_DONE    = 2'b01;
    localparam logic [1:0] STOP_TIMEOUT = 2'b10;
    localparam logic [1:0] STOP_ABORT   = 2'b11;

    localparam logic [CNT_W-1:0] CYCLE_LIMIT = CNT_W'(MAX_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETPC,
        S_RUN,
        S_FINISH
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data;
    logic [DATA_W-1:0] r_pc_set_val;
    logic [1:0]        r_stop_reason;
    logic [CNT_W-1:0]  r_cycle_count;
`ifdef SIMPROC_CTRL_BKPT_EN
    logic              r_bkpt_hit;
`endif

    logic              w_cmd_ready;
    logic              w_accept;
    logic [CNT_W-1:0]  w_count_next;

    // The start PC comes in on the address field; copy the overlapping low
    // bits so the result is zero-extended or truncated for any width pairing.
    function automatic logic [DATA_W-1:0] fitPc(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        v = '0;
        for (int i = 0; i < DATA_W && i < ADDR_W; i++) begin
            v[i] = a[i];
        end
        return v;
    endfunction

    // Only ABORT may get through while the processor is running; any other
    // command is held off until the controller is back in IDLE.
    always_comb begin
        w_cmd_ready = 1'b0;
        case (r_state)
            S_IDLE:  w_cmd_ready = 1'b1;
            S_RUN:   w_cmd_ready = (cmd_op == OP_ABORT);
            default: w_cmd_ready = 1'b0;
        endcase
    end

    assign w_accept     = cmd_valid && w_cmd_ready;
    assign w_count_next = r_cycle_count + CNT_W'(1);

    // Program memory is not reset. The host writes only in IDLE and the
    // processor writes only in RUN, so the two write ports never collide.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && w_accept && cmd_op == OP_WRITE) begin
            r_mem[cmd_addr] <= cmd_wdata;
        end else if (r_state == S_RUN && cpu_mem_we) begin
            r_mem[cpu_mem_addr] <= cpu_mem_din;
        end
    end

    // Controller FSM. In RUN the exit checks are ordered by priority; the
    // exiting cycle still counts, so the counter always takes w_count_next.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_rsp_valid   <= 1'b0;
            r_rsp_data    <= '0;
            r_pc_set_val  <= '0;
            r_stop_reason <= STOP_NONE;
            r_cycle_count <= '0;
`ifdef SIMPROC_CTRL_BKPT_EN
            r_bkpt_hit    <= 1'b0;
`endif
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        case (cmd_op)
                            OP_READ: begin
                                r_rsp_valid <= 1'b1;
                                r_rsp_data  <= r_mem[cmd_addr];
                            end
                            OP_START: begin
                                r_pc_set_val  <= fitPc(cmd_addr);
                                r_cycle_count <= '0;
                                r_stop_reason <= STOP_NONE;
`ifdef SIMPROC_CTRL_BKPT_EN
                                r_bkpt_hit    <= 1'b0;
`endif
                                r_state       <= S_SETPC;
                            end
                            default: begin
                            end
                        endcase
                    end
                end
                S_SETPC: begin
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    r_cycle_count <= w_count_next;
                    if (w_accept) begin
                        r_stop_reason <= STOP_ABORT;
                        r_state       <= S_FINISH;
                    end else if (cpu_done) begin
                        r_stop_reason <= STOP_DONE;
                        r_state       <= S_FINISH;
`ifdef SIMPROC_CTRL_BKPT_EN
                    end else if (bkpt_en && cpu_mem_addr == bkpt_addr) begin
                        r_stop_reason <= STOP_DONE;
                        r_bkpt_hit    <= 1'b1;
                        r_state       <= S_FINISH;
`endif
                    end else if (w_count_next == CYCLE_LIMIT) begin
                        r_stop_reason <= STOP_TIMEOUT;
                        r_state       <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Strobes decode straight from the state register so an asynchronous
    // reset drops them immediately.
    assign cpu_run        = (r_state == S_RUN);
    assign cpu_pc_set_wr  = (r_state == S_SETPC);
    assign busy           = (r_state != S_IDLE);
    assign cmd_ready      = w_cmd_ready;
    assign rsp_valid      = r_rsp_valid;
    assign rsp_data       = r_rsp_data;
    assign cpu_pc_set_val = r_pc_set_val;
    assign stop_reason    = r_stop_reason;
    assign cycle_count    = r_cycle_count;
    assign cpu_mem_dout   = r_mem[cpu_mem_addr];
`ifdef SIMPROC_CTRL_BKPT_EN
    assign bkpt_hit       = r_bkpt_hit;
`endif

endmodule

// File: tb/tb_simproc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_simproc_ctrl
//
// Scoreboard bench for simproc_ctrl. Host commands and processor stub
// activity are driven from the main initial block; READ responses and run
// outcomes are predicted from a plain memory array and simple run arithmetic
// (earliest of abort / done / budget, abort winning ties over done, done
// over budget). Separate monitors pop the predictions when the DUT presents
// a response or finishes a run.
// ---------------------------------------------------------------------------
module tb_simproc_ctrl;

    localparam int DATA_W     = 8;
    localparam int ADDR_W     = 8;
    localparam int CNT_W      = 16;
    localparam int MAX_CYCLES = 16;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_START = 2'b10;
    localparam logic [1:0] OP_ABORT = 2'b11;

    logic              clk;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic [ADDR_W-1:0] cpu_mem_addr;
    logic [DATA_W-1:0] cpu_mem_din;
    logic              cpu_mem_we;
    logic [DATA_W-1:0] cpu_mem_dout;
    logic [DATA_W-1:0] cpu_pc_set_val;
    logic              cpu_pc_set_wr;
    logic              cpu_run;
    logic              cpu_done;
    logic              busy;
    logic [1:0]        stop_reason;
    logic [CNT_W-1:0]  cycle_count;

    simproc_ctrl #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .CNT_W     (CNT_W),
        .MAX_CYCLES(MAX_CYCLES)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .cpu_mem_addr  (cpu_mem_addr),
        .cpu_mem_din   (cpu_mem_din),
        .cpu_mem_we    (cpu_mem_we),
        .cpu_mem_dout  (cpu_mem_dout),
        .cpu_pc_set_val(cpu_pc_set_val),
        .cpu_pc_set_wr (cpu_pc_set_wr),
        .cpu_run       (cpu_run),
        .cpu_done      (cpu_done),
        .busy          (busy),
        .stop_reason   (stop_reason),
        .cycle_count   (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tbCycle = 0;
    always @(posedge clk) tbCycle++;

    int checks   = 0;
    int failures = 0;

    // Reference state: memory image and expectation queues.
    logic [DATA_W-1:0] modelMem [256];
    bit                written  [256];

    typedef struct {
        int                cyc;
        logic [DATA_W-1:0] data;
    } rspExp_t;

    typedef struct {
        logic [1:0]        reason;
        int                count;
        logic [DATA_W-1:0] pc;
    } runExp_t;

    rspExp_t rspQ[$];
    runExp_t runQ[$];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, actual, expected, tbCycle);
        end
    endtask

    // Issue one host command, wait (bounded) for acceptance, then update the
    // reference model as of the accepting edge.
    task automatic applyStimulus(input logic [1:0] op, input logic [7:0] addr,
                                 input logic [7:0] data);
        bit      got;
        rspExp_t e;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_wdata = data;
        got       = 1'b0;
        for (int w = 0; w < 200 && !got; w++) begin
            @(negedge clk);
            got = cmd_ready;
            @(posedge clk);
        end
        #1;
        cmd_valid = 1'b0;
        if (!got) begin
            checkOutput("cmd_accept_timeout", 32'd0, 32'd1);
        end else if (op == OP_WRITE) begin
            modelMem[addr] = data;
            written[addr]  = 1'b1;
        end else if (op == OP_READ) begin
            e.cyc  = tbCycle;
            e.data = modelMem[addr];
            rspQ.push_back(e);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_cmd_ready"},   cmd_ready,      32'd1);
        checkOutput({tag, "_rsp_valid"},   rsp_valid,      32'd0);
        checkOutput({tag, "_rsp_data"},    rsp_data,       32'd0);
        checkOutput({tag, "_pc_set_val"},  cpu_pc_set_val, 32'd0);
        checkOutput({tag, "_pc_set_wr"},   cpu_pc_set_wr,  32'd0);
        checkOutput({tag, "_cpu_run"},     cpu_run,        32'd0);
        checkOutput({tag, "_busy"},        busy,           32'd0);
        checkOutput({tag, "_stop_reason"}, stop_reason,    32'd0);
        checkOutput({tag, "_cycle_count"}, cycle_count,    32'd0);
    endtask

    // One run: predict the outcome, START, then play the processor stub
    // cycle by cycle. cpuWr: 0 none, 1 write 0x5A to 0xC0 in cycle 1,
    // 2 random writes.
    task automatic runProgram(input logic [7:0] pc, input int doneAt,
                              input int abortAt, input bit stallWrite,
                              input int cpuWr, input logic [7:0] stallAddr,
                              input logic [7:0] stallData);
        int      endCyc;
        runExp_t r;
        endCyc   = MAX_CYCLES;
        r.reason = 2'b10;
        if (doneAt > 0 && doneAt <= endCyc) begin
            endCyc   = doneAt;
            r.reason = 2'b01;
        end
        if (abortAt > 0 && abortAt <= endCyc) begin
            endCyc   = abortAt;
            r.reason = 2'b11;
        end
        r.count = endCyc;
        r.pc    = pc;
        runQ.push_back(r);
        applyStimulus(OP_START, pc, 8'h00);
        @(posedge clk);
        #1;
        for (int k = 1; k <= endCyc; k++) begin
            cpu_done   = (k == doneAt);
            cmd_valid  = 1'b0;
            cpu_mem_we = 1'b0;
            if (k == abortAt) begin
                cmd_valid = 1'b1;
                cmd_op    = OP_ABORT;
                cmd_addr  = 8'($urandom);
            end else if (stallWrite) begin
                cmd_valid = 1'b1;
                cmd_op    = OP_WRITE;
                cmd_addr  = stallAddr;
                cmd_wdata = stallData;
            end
            if (cpuWr == 1 && k == 1) begin
                cpu_mem_we   = 1'b1;
                cpu_mem_addr = 8'hC0;
                cpu_mem_din  = 8'h5A;
            end else if (cpuWr == 2 && $urandom_range(0, 1) == 1) begin
                cpu_mem_we   = 1'b1;
                cpu_mem_addr = 8'($urandom);
                cpu_mem_din  = 8'($urandom);
            end
            if (cpu_mem_we) begin
                modelMem[cpu_mem_addr] = cpu_mem_din;
                written[cpu_mem_addr]  = 1'b1;
            end
            @(negedge clk);
            if (cmd_valid) begin
                checkOutput((cmd_op == OP_ABORT) ? "ready_abort" : "ready_stall",
                            cmd_ready, (cmd_op == OP_ABORT));
            end
            @(posedge clk);
            #1;
        end
        cpu_done   = 1'b0;
        cmd_valid  = 1'b0;
        cpu_mem_we = 1'b0;
        for (int g = 0; g < MAX_CYCLES + 8 && busy; g++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("busy_after_run", busy, 32'd0);
        checkOutput("ready_after_run", cmd_ready, 32'd1);
    endtask

    // Response monitor: every rsp_valid pulse must match the oldest
    // outstanding READ, on the cycle right after it was accepted.
    always @(negedge clk) begin : rspMonitor
        rspExp_t e;
        if (rst && rsp_valid) begin
            if (rspQ.size() == 0) begin
                checkOutput("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                e = rspQ.pop_front();
                checkOutput("rsp_data", rsp_data, e.data);
                checkOutput("rsp_latency", tbCycle, e.cyc);
            end
        end
    end

    // Run monitor: counts PC-load and run cycles, and on the FINISH cycle
    // (busy with neither strobe) compares the run outcome.
    int                runCycles   = 0;
    int                pcSetCycles = 0;
    logic [DATA_W-1:0] seenPc      = '0;

    always @(negedge clk) begin : runMonitor
        runExp_t r;
        if (!rst) begin
            runCycles   = 0;
            pcSetCycles = 0;
        end else begin
            if (cpu_pc_set_wr) begin
                pcSetCycles++;
                seenPc = cpu_pc_set_val;
            end
            if (cpu_run) runCycles++;
            if (busy && !cpu_run && !cpu_pc_set_wr) begin
                if (runQ.size() == 0) begin
                    checkOutput("run_unexpected", 32'd1, 32'd0);
                end else begin
                    r = runQ.pop_front();
                    checkOutput("stop_reason", stop_reason, r.reason);
                    checkOutput("cycle_count", cycle_count, r.count);
                    checkOutput("cpu_run_cycles", runCycles, r.count);
                    checkOutput("pc_set_wr_cycles", pcSetCycles, 32'd1);
                    checkOutput("pc_set_val", seenPc, r.pc);
                end
                runCycles   = 0;
                pcSetCycles = 0;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : mainSeq
        logic [7:0] a;
        logic [7:0] d;
        int         ab;
        rst          = 1'b0;
        cmd_valid    = 1'b0;
        cmd_op       = OP_WRITE;
        cmd_addr     = '0;
        cmd_wdata    = '0;
        cpu_mem_addr = '0;
        cpu_mem_din  = '0;
        cpu_mem_we   = 1'b0;
        cpu_done     = 1'b0;
        #2;
        checkResetValues("por");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Load, read back, processor-side combinational read.
        applyStimulus(OP_WRITE, 8'h00, 8'h90);
        applyStimulus(OP_WRITE, 8'h01, 8'h44);
        applyStimulus(OP_WRITE, 8'h02, 8'h47);
        applyStimulus(OP_WRITE, 8'h03, 8'hA8);
        applyStimulus(OP_READ,  8'h02, 8'h00);
        cpu_mem_addr = 8'h03;
        #1;
        checkOutput("cpu_dout_03", cpu_mem_dout, 32'hA8);

        // Read-after-write on back-to-back commands.
        d = 8'($urandom);
        applyStimulus(OP_WRITE, 8'h10, d);
        applyStimulus(OP_READ,  8'h10, 8'h00);

        // Normal run ending on cpu_done in cycle 7, then ABORT while idle.
        runProgram(8'h05, 7, 0, 1'b0, 0, 8'h00, 8'h00);
        applyStimulus(OP_ABORT, 8'h00, 8'h00);
        checkOutput("idle_abort_busy", busy, 32'd0);
        checkOutput("idle_abort_reason", stop_reason, 32'd1);
        checkOutput("idle_abort_count", cycle_count, 32'd7);

        // Budget exhaustion with cpu_done never asserted.
        runProgram(8'h2A, 0, 0, 1'b0, 0, 8'h00, 8'h00);

        // Stalled WRITE during RUN, then ABORT coinciding with cpu_done.
        ab = $urandom_range(3, 10);
        d  = 8'($urandom);
        runProgram(8'h11, ab, ab, 1'b1, 0, 8'h77, d);
        applyStimulus(OP_WRITE, 8'h77, d);
        applyStimulus(OP_READ,  8'h77, 8'h00);

        // Processor write during RUN lands; the same write in IDLE is ignored.
        runProgram(8'h40, 4, 0, 1'b0, 1, 8'h00, 8'h00);
        applyStimulus(OP_READ, 8'hC0, 8'h00);
        cpu_mem_we   = 1'b1;
        cpu_mem_addr = 8'hC0;
        cpu_mem_din  = 8'h11;
        repeat (3) @(posedge clk);
        #1;
        cpu_mem_we = 1'b0;
        checkOutput("cpu_dout_c0_idle_we", cpu_mem_dout, 32'h5A);
        applyStimulus(OP_READ, 8'hC0, 8'h00);

        // Randomised runs with random processor writes.
        for (int i = 0; i < 6; i++) begin
            runProgram(8'($urandom), $urandom_range(0, 20), $urandom_range(0, 20),
                       1'b0, 2, 8'h00, 8'h00);
        end

        // Random readback through both ports.
        for (int i = 0; i < 8; i++) begin
            a = 8'($urandom);
            if (!written[a]) applyStimulus(OP_WRITE, a, 8'($urandom));
            applyStimulus(OP_READ, a, 8'h00);
            cpu_mem_addr = a;
            #1;
            checkOutput("cpu_dout_rand", cpu_mem_dout, modelMem[a]);
        end
        repeat (2) @(posedge clk);
        #1;

        // Reset in the middle of a run (no outcome expected for it).
        applyStimulus(OP_START, 8'h20, 8'h00);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("midrun_busy", busy, 32'd1);
        checkOutput("midrun_cpu_run", cpu_run, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        checkResetValues("midrun_rst");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Memory survives reset.
        applyStimulus(OP_READ, 8'h02, 8'h00);
        applyStimulus(OP_READ, 8'hC0, 8'h00);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rsp_queue_drained", rspQ.size(), 32'd0);
        checkOutput("run_queue_drained", runQ.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
